// File: rtl/rv32_pkg.sv
// Shared RV32 constants and load/store unit types.
// The legality check lives here so it stays next to the func3 encodings it depends on.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // True for anything that must complete with err and never touch the bus.
  function automatic logic lsu_illegal(input logic       rd_flag,
                                       input logic       wr_flag,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = (rd_flag == wr_flag);
    if (rd_flag && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) bad = 1'b1;
    if (wr_flag && (f3 >= 3'b011)) bad = 1'b1;
    if (f3[1:0] == 2'b01 && addr_lo[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core's LSB-justified data and the 32-bit bus.
// Purely combinational; only called with legal, aligned func3/addr_lo pairs.
module lsu_lane_align
  import rv32_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_data,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be        = 4'b1111;
    bus_wdata = store_data;
    case (func3[1:0])
      2'b00: begin
        be        = 4'(4'b0001 << addr_lo);
        bus_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be        = 4'(4'b0011 << addr_lo);
        bus_wdata = {2{store_data[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        bus_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    lane_b = bus_data[7:0];
    case (addr_lo)
      2'd0: lane_b = bus_data[7:0];
      2'd1: lane_b = bus_data[15:8];
      2'd2: lane_b = bus_data[23:16];
      2'd3: lane_b = bus_data[31:24];
      default: lane_b = bus_data[7:0];
    endcase
    lane_h = addr_lo[1] ? bus_data[31:16] : bus_data[15:0];
  end

  // func3[2] selects zero extension (lbu/lhu).
  always_comb begin
    load_data = bus_data;
    case (func3[1:0])
      2'b00:   load_data = {{24{lane_b[7] & ~func3[2]}}, lane_b};
      2'b01:   load_data = {{16{lane_h[15] & ~func3[2]}}, lane_h};
      default: load_data = bus_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding access, aligned 32-bit bus with byte
// enables, sign/zero-extended load return and a pipeline stall while busy.
//
// state | meaning
// IDLE  | ready; request captured on req_valid
// REQ   | bus request held until dmem_gnt (illegal access: one silent cycle, no bus)
// WAIT  | load granted, waiting for dmem_rvalid
// RESP  | one-cycle done pulse
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_in,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [4:0]        rd_out,
  output logic              rd_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [4:0]        rd_q;
  logic              rd_flag_q;
  logic              wr_flag_q;
  logic              err_q;
  logic              accept;

  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_load;

  assign accept = (state == IDLE) && req_valid;

  lsu_lane_align u_lane_align (
    .func3      (func3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (wdata_q),
    .bus_data   (dmem_rdata),
    .be         (lane_be),
    .bus_wdata  (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Illegal accesses still pass through REQ (with the bus gated off) so the
  // error completion lands two cycles after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = REQ;
      REQ: begin
        if (err_q)         state_nxt = RESP;
        else if (dmem_gnt) state_nxt = wr_flag_q ? RESP : WAIT;
      end
      WAIT: if (dmem_rvalid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    done       = (state == RESP);
    err        = done && err_q;
    rd_we      = done && rd_flag_q && !err_q;
    dmem_req   = (state == REQ) && !err_q;
    dmem_we    = dmem_req && wr_flag_q;
    dmem_be    = dmem_req ? lane_be : 4'b0000;
    dmem_wdata = dmem_req ? lane_wdata : 32'h0;
    dmem_addr  = dmem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      func3_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= '0;
      rd_flag_q <= 1'b0;
      wr_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      addr_q    <= addr;
      func3_q   <= func3;
      wdata_q   <= wdata;
      rdata_q   <= '0;
      rd_q      <= rd_in;
      rd_flag_q <= mem_read;
      wr_flag_q <= mem_write;
      err_q     <= lsu_illegal(mem_read, mem_write, func3, addr[1:0]);
    end else if (state == WAIT && dmem_rvalid) begin
      rdata_q   <= lane_load;
    end
  end

  assign rdata  = rdata_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses with a
// reactive memory model, plus back-to-back and reset-abort sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        req_ready, busy, done, err, rd_we;
  logic [31:0] rdata;
  logic [4:0]  rd_out;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .func3(func3), .addr(addr), .wdata(wdata),
    .rd_in(rd_in), .req_ready(req_ready), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .rd_out(rd_out), .rd_we(rd_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        rd_f;
    logic        wr_f;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic [4:0]  rd;
    int          gw;
    int          rw;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  task automatic idle_inputs();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    func3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; rd_in = 5'd31;
  endtask

  // One access against a memory that grants after v.gw REQ cycles and returns
  // data after v.rw WAIT cycles.
  task automatic run_vec(input string nm, input vec_t v);
    int n, req_cnt, wt_cnt;
    bit got_gnt, saw_req, fin, busy_ok;
    logic [31:0] a_addr, a_wd, r_data;
    logic [3:0]  a_be;
    logic        a_we, r_err, r_we;
    logic [4:0]  r_rd;
    n = 1; req_cnt = 0; wt_cnt = 0; got_gnt = 0; saw_req = 0; fin = 0; busy_ok = 1;
    a_addr = '0; a_wd = '0; a_be = '0; a_we = 0; r_data = '0; r_err = 0; r_we = 0; r_rd = '0;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; mem_read = v.rd_f; mem_write = v.wr_f; func3 = v.f3;
    addr = v.addr; wdata = v.wdata; rd_in = v.rd; dmem_rdata = v.mrdata;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    while (!fin && n <= 30) begin
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (busy !== !req_ready) busy_ok = 0;
      if (done === 1'b1) begin
        fin = 1; r_err = err; r_data = rdata; r_we = rd_we; r_rd = rd_out;
      end else begin
        if (req_ready !== 1'b0) busy_ok = 0;
        if (dmem_req === 1'b1) begin
          saw_req = 1; a_addr = dmem_addr; a_be = dmem_be; a_wd = dmem_wdata; a_we = dmem_we;
          req_cnt++;
          if (req_cnt > v.gw) begin dmem_gnt = 1'b1; got_gnt = 1; end
        end else if (got_gnt) begin
          wt_cnt++;
          if (wt_cnt > v.rw) dmem_rvalid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    chk({nm, "_done_seen"}, {31'd0, fin}, 32'd1);
    if (fin) begin
      chk({nm, "_latency"}, n, v.exp_lat);
      chk({nm, "_err"}, {31'd0, r_err}, {31'd0, v.exp_err});
      chk({nm, "_rdata"}, r_data, v.exp_rdata);
      chk({nm, "_rd_we"}, {31'd0, r_we}, {31'd0, v.rd_f && !v.wr_f && !v.exp_err});
      chk({nm, "_busy"}, {31'd0, busy_ok}, 32'd1);
      chk({nm, "_bus_used"}, {31'd0, saw_req}, {31'd0, !v.exp_err});
      if (!v.exp_err) begin
        chk({nm, "_dmem_addr"}, a_addr, v.addr & 32'hFFFF_FFFC);
        chk({nm, "_dmem_be"}, {28'd0, a_be}, {28'd0, v.exp_be});
        chk({nm, "_dmem_wdata"}, a_wd, v.exp_wdata);
        chk({nm, "_dmem_we"}, {31'd0, a_we}, {31'd0, v.wr_f});
      end
      if (v.rd_f && !v.wr_f && !v.exp_err) chk({nm, "_rd_out"}, {27'd0, r_rd}, {27'd0, v.rd});
      @(negedge clk);
      chk({nm, "_done_pulse"}, {30'd0, done, req_ready}, 32'd1);
    end
  endtask

  function automatic vec_t mk(input logic rd_f, input logic wr_f, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] mr, input logic [4:0] rd,
                              input int gw, input int rw, input logic e,
                              input logic [31:0] er, input logic [3:0] eb,
                              input logic [31:0] ew, input int lat);
    vec_t v;
    v.rd_f = rd_f; v.wr_f = wr_f; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrdata = mr;
    v.rd = rd; v.gw = gw; v.rw = rw; v.exp_err = e; v.exp_rdata = er; v.exp_be = eb;
    v.exp_wdata = ew; v.exp_lat = lat;
    return v;
  endfunction

  vec_t vecs[$];
  int   dones, accepts;
  logic [31:0] b2b_rdata;

  initial begin
    rst = 1'b1; idle_inputs();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    //          rd wr f3      addr          wdata         mem rdata     rd  gw rw err exp_rdata     be       exp_wdata     lat
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,        5'd0, 2, 0, 0, 32'h0,        4'b1000, 32'hA5A5_A5A5, 4));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_2001, 32'h0,        32'h1234_8056, 5'd5, 0, 0, 0, 32'hFFFF_FF80, 4'b0010, 32'h0,        3));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_2001, 32'h0,        32'h1234_8056, 5'd6, 0, 0, 0, 32'h0000_0080, 4'b0010, 32'h0,        3));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 5'd7, 0, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0,        3));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 5'd8, 1, 0, 0, 32'h0000_8001, 4'b1100, 32'h0,        4));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,        5'd9, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_3000, 32'h0,        32'h0,        5'd9, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 5'd10, 1, 2, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,       6));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_4006, 32'h1234_ABCD, 32'h0,        5'd0, 0, 0, 0, 32'h0,        4'b1100, 32'hABCD_ABCD, 2));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_4008, 32'h1122_3344, 32'h0,        5'd0, 0, 0, 0, 32'h0,        4'b1111, 32'h1122_3344, 2));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_5003, 32'h0,        32'h7F00_0000, 5'd11, 0, 1, 0, 32'h0000_007F, 4'b1000, 32'h0,       4));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_5000, 32'h0,        32'h0000_FFFE, 5'd12, 0, 0, 0, 32'h0000_FFFE, 4'b0011, 32'h0,       3));
    vecs.push_back(mk(0, 1, 3'b011, 32'h0000_6000, 32'h0,        32'h0,        5'd0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));
    vecs.push_back(mk(1, 0, 3'b110, 32'h0000_6000, 32'h0,        32'h0,        5'd1, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));
    vecs.push_back(mk(0, 0, 3'b010, 32'h0000_6000, 32'h0,        32'h0,        5'd1, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_6001, 32'h0,        32'h0,        5'd0, 0, 0, 1, 32'h0,        4'b0000, 32'h0,        2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outputs", {26'd0, busy, done, err, rd_we, dmem_req, dmem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back lw then sw with req_valid held and an immediate memory.
    @(negedge clk);
    dones = 0; accepts = 0; b2b_rdata = '0;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
    addr = 32'h0000_7000; wdata = 32'h0; rd_in = 5'd3; dmem_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < 12; c++) begin
      dmem_gnt = dmem_req;
      dmem_rvalid = busy && !dmem_req && !done && !req_ready && (c == 2);
      if (busy !== !req_ready) chk("b2b_busy", {31'd0, busy}, {31'd0, !req_ready});
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) b2b_rdata = rdata;
      end
      if (req_ready === 1'b1 && req_valid) begin
        accepts++;
        @(posedge clk);
        @(negedge clk);
        if (accepts == 1) begin
          mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010; addr = 32'h0000_7004;
          wdata = 32'h5555_AAAA;
        end else idle_inputs();
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    idle_inputs();
    chk("b2b_accepts", accepts, 2);
    chk("b2b_dones", dones, 2);
    chk("b2b_load_rdata", b2b_rdata, 32'hCAFE_F00D);

    // Reset while a load is in WAIT, then a stray rvalid.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
    addr = 32'h0000_8000; rd_in = 5'd4; dmem_rdata = 32'h1111_2222;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    chk("rstmid_req", {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstmid_in_wait", {29'd0, busy, dmem_req, done}, 32'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_idle", {29'd0, req_ready, dmem_req, done}, 32'd4);
    dmem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rstmid_no_done", {29'd0, req_ready, dmem_req, done}, 32'd4);
    chk("rstmid_rdata", rdata, 32'h0);
    run_vec("after_rst", mk(1, 0, 3'b010, 32'h0000_8004, 32'h0, 32'h3333_4444, 5'd13,
                            0, 0, 0, 32'h3333_4444, 4'b1111, 32'h0, 3));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
